// File: rtl/wb_pkg.sv
// Shared types for the MEM->WB stage buffer: state encoding, default widths
// and the buffered writeback entry.
package wb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b10
    } wb_state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] alu_out;
        logic [DEF_DATA_W-1:0] read_data;
        logic [DEF_REG_AW-1:0] write_reg;
        logic                  reg_write;
        logic                  mem_to_reg;
    } wb_entry_t;

endpackage

// File: rtl/wb_slot.sv
// One buffered writeback entry: loadable register, cleared by async active-low reset.
// The entry type is a parameter so the top can widen it beyond the package default.
module wb_slot
    import wb_pkg::*;
#(
    parameter type entry_t = wb_entry_t
) (
    input  logic   CLK,
    input  logic   RST,
    input  logic   ld_i,
    input  entry_t d_i,
    output entry_t q_o
);

    entry_t slot_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)      slot_q <= '0;
        else if (ld_i) slot_q <= d_i;
    end

    assign q_o = slot_q;

endmodule

// File: rtl/wb_stage_buf.sv
// MEM->WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Optional performance counters (RetireCnt/StallCnt) are built with WB_PERF_CNT_EN.
module wb_stage_buf
    import wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Flush,
    input  logic              ValidM,
    output logic              ReadyM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] ReadDataM,
    input  logic [REG_AW-1:0] WriteRegM,
    input  logic              RegWriteM,
    input  logic              MemtoRegM,
    output logic              ValidW,
    input  logic              ReadyW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [REG_AW-1:0] WriteRegW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [DATA_W-1:0] ResultW
`ifdef WB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  RetireCnt,
    output logic [CNT_W-1:0]  StallCnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_out;
        logic [DATA_W-1:0] read_data;
        logic [REG_AW-1:0] write_reg;
        logic              reg_write;
        logic              mem_to_reg;
    } entry_t;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("wb_stage_buf: CNT_W must be at least 1");
    end

    wb_state_t state_q, state_d;
    logic      ready_q;
    logic      accept, drain, valid;
    logic      main_ld, skid_ld;
    entry_t    in_e, main_d, main_q, skid_q;

    assign valid  = (state_q != EMPTY);
    assign accept = ValidM & ready_q;
    assign drain  = valid & ReadyW;

    // Writes to R0 are architecturally void, so drop the enable at capture.
    always_comb begin
        in_e            = '0;
        in_e.alu_out    = ALUOutM;
        in_e.read_data  = ReadDataM;
        in_e.write_reg  = WriteRegM;
        in_e.reg_write  = RegWriteM & (WriteRegM != '0);
        in_e.mem_to_reg = MemtoRegM;
    end

    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        skid_ld = 1'b0;
        main_d  = in_e;
        if (Flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    main_ld = 1'b1;
                    state_d = FULL;
                end
                FULL: begin
                    if (accept && drain) begin
                        main_ld = 1'b1;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end else if (accept) begin
                        skid_ld = 1'b1;
                        state_d = SKID;
                    end
                end
                SKID: if (drain) begin
                    main_ld = 1'b1;
                    main_d  = skid_q;
                    state_d = FULL;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // ReadyM is registered from the next state so ReadyW never reaches it combinationally.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != SKID);
        end
    end

    wb_slot #(.entry_t(entry_t)) u_main (
        .CLK (CLK), .RST (RST), .ld_i (main_ld), .d_i (main_d), .q_o (main_q)
    );

    wb_slot #(.entry_t(entry_t)) u_skid (
        .CLK (CLK), .RST (RST), .ld_i (skid_ld), .d_i (in_e), .q_o (skid_q)
    );

    assign ReadyM    = ready_q;
    assign ValidW    = valid;
    assign ALUOutW   = main_q.alu_out;
    assign ReadDataW = main_q.read_data;
    assign WriteRegW = main_q.write_reg;
    assign RegWriteW = main_q.reg_write & valid;
    assign MemtoRegW = main_q.mem_to_reg;
    assign ResultW   = main_q.mem_to_reg ? main_q.read_data : main_q.alu_out;

`ifdef WB_PERF_CNT_EN
    logic [CNT_W-1:0] retire_q, stall_q;

    // Counters ignore Flush on purpose: they track retired work and lost cycles.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            retire_q <= '0;
            stall_q  <= '0;
        end else begin
            if (drain && RegWriteW) retire_q <= retire_q + 1'b1;
            if (valid && !ReadyW)   stall_q  <= stall_q + 1'b1;
        end
    end

    assign RetireCnt = retire_q;
    assign StallCnt  = stall_q;
`endif

endmodule

// File: tb/tb_wb_stage_buf.sv
// Self-checking bench for wb_stage_buf: directed steps plus a random phase,
// checked against a queue-based reference model. Counter checks need WB_PERF_CNT_EN.
module tb_wb_stage_buf;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        Flush = 1'b0, ValidM = 1'b0, ReadyW = 1'b0;
    logic [31:0] ALUOutM = '0, ReadDataM = '0;
    logic [4:0]  WriteRegM = '0;
    logic        RegWriteM = 1'b0, MemtoRegM = 1'b0;

    logic        ReadyM, ValidW, RegWriteW, MemtoRegW;
    logic [31:0] ALUOutW, ReadDataW, ResultW;
    logic [4:0]  WriteRegW;
`ifdef WB_PERF_CNT_EN
    logic [31:0] RetireCnt, StallCnt;
`endif

    wb_stage_buf dut (
        .CLK(CLK), .RST(RST), .Flush(Flush),
        .ValidM(ValidM), .ReadyM(ReadyM),
        .ALUOutM(ALUOutM), .ReadDataM(ReadDataM), .WriteRegM(WriteRegM),
        .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .ValidW(ValidW), .ReadyW(ReadyW),
        .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .WriteRegW(WriteRegW),
        .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .ResultW(ResultW)
`ifdef WB_PERF_CNT_EN
        , .RetireCnt(RetireCnt), .StallCnt(StallCnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rd;
        logic [4:0]  wr;
        logic        rw;
        logic        mtr;
    } ent_t;

    ent_t        mq[$];
    int unsigned m_ret = 0, m_stall = 0;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        logic v;
        v = (mq.size() > 0);
        chk("ValidW", ValidW, v);
        chk("ReadyM", ReadyM, mq.size() < 2);
        chk("RegWriteW", RegWriteW, v ? mq[0].rw : 1'b0);
        if (v) begin
            chk("ALUOutW", ALUOutW, mq[0].alu);
            chk("ReadDataW", ReadDataW, mq[0].rd);
            chk("WriteRegW", WriteRegW, mq[0].wr);
            chk("MemtoRegW", MemtoRegW, mq[0].mtr);
            chk("ResultW", ResultW, mq[0].mtr ? mq[0].rd : mq[0].alu);
        end
`ifdef WB_PERF_CNT_EN
        chk("RetireCnt", RetireCnt, m_ret);
        chk("StallCnt", StallCnt, m_stall);
`endif
    endtask

    task automatic model_edge();
        ent_t e;
        logic v, dr, ac;
        if (!RST) begin
            mq.delete();
            m_ret = 0;
            m_stall = 0;
        end else begin
            v  = (mq.size() > 0);
            dr = v && ReadyW;
            ac = ValidM && (mq.size() < 2);
            if (v && !ReadyW) m_stall++;
            if (dr && mq[0].rw) m_ret++;
            if (Flush) begin
                mq.delete();
            end else begin
                if (dr) void'(mq.pop_front());
                if (ac) begin
                    e.alu = ALUOutM; e.rd = ReadDataM; e.wr = WriteRegM;
                    e.rw  = RegWriteM && (WriteRegM != 0); e.mtr = MemtoRegM;
                    mq.push_back(e);
                end
            end
        end
    endtask

    // Check at the falling edge, let the model advance with the DUT at the rising edge.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            check_model();
            @(posedge CLK);
            model_edge();
            #1;
        end
    endtask

    task automatic setin(input logic v, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [4:0] wr, input logic rw, input logic mtr);
        ValidM = v; ALUOutM = alu; ReadDataM = rd; WriteRegM = wr;
        RegWriteM = rw; MemtoRegM = mtr;
    endtask

    initial begin
        // Reset held with a valid upstream entry
        setin(1'b1, 32'h55, 32'h66, 5'd3, 1'b1, 1'b0);
        ReadyW = 1'b1;
        step(2);
        chk("rst_ValidW", ValidW, 1'b0);
        chk("rst_RegWriteW", RegWriteW, 1'b0);
        chk("rst_ReadyM", ReadyM, 1'b1);
        chk("rst_ResultW", ResultW, 32'h0);
        chk("rst_ALUOutW", ALUOutW, 32'h0);
        setin(1'b0, '0, '0, '0, 1'b0, 1'b0);
        RST = 1'b1;
        step(2);
        chk("idle_ValidW", ValidW, 1'b0);

        // Streaming at full rate
        for (int i = 1; i <= 4; i++) begin
            setin(1'b1, 32'(i * 16), 32'hAA00 + 32'(i), 5'(i), 1'b1, 1'b0);
            step();
            chk("stream_ReadyM", ReadyM, 1'b1);
            chk("stream_ResultW", ResultW, 32'(i * 16));
        end
        setin(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step(2);

        // Backpressure into the skid slot
        ReadyW = 1'b0;
        setin(1'b1, 32'h1111, 32'hDEAD, 5'd9, 1'b1, 1'b1);
        step();
        setin(1'b1, 32'h2222, 32'hBEEF, 5'd10, 1'b1, 1'b0);
        step();
        setin(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step(2);
        chk("skid_ReadyM", ReadyM, 1'b0);
        chk("skid_ResultW", ResultW, 32'hDEAD);
        ReadyW = 1'b1;
        step();
        chk("drainA_ResultW", ResultW, 32'h2222);
        step(2);
        chk("drained_ValidW", ValidW, 1'b0);

        // R0 write suppression
        setin(1'b1, 32'h77, 32'h0, 5'd0, 1'b1, 1'b0);
        step();
        chk("r0_ValidW", ValidW, 1'b1);
        chk("r0_RegWriteW", RegWriteW, 1'b0);
        setin(1'b1, 32'h88, 32'h0, 5'd7, 1'b1, 1'b0);
        step();
        chk("r7_RegWriteW", RegWriteW, 1'b1);
        setin(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step();

        // Flush while in SKID with a new entry arriving
        ReadyW = 1'b0;
        setin(1'b1, 32'h301, 32'h0, 5'd1, 1'b1, 1'b0);
        step();
        setin(1'b1, 32'h302, 32'h0, 5'd2, 1'b1, 1'b0);
        step();
        Flush = 1'b1;
        setin(1'b1, 32'hBAD, 32'hBAD, 5'd5, 1'b1, 1'b1);
        step();
        Flush = 1'b0;
        setin(1'b0, '0, '0, '0, 1'b0, 1'b0);
        chk("flush_ValidW", ValidW, 1'b0);
        chk("flush_RegWriteW", RegWriteW, 1'b0);
        chk("flush_ReadyM", ReadyM, 1'b1);
        ReadyW = 1'b1;
        step(3);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            setin($urandom_range(0, 3) != 0, $urandom, $urandom,
                  ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            ReadyW = $urandom_range(0, 2) != 0;
            Flush  = $urandom_range(0, 30) == 0;
            step();
        end
        Flush = 1'b0;

        // Async reset while SKID is occupied
        ReadyW = 1'b0;
        setin(1'b1, 32'h401, 32'h0, 5'd1, 1'b1, 1'b0);
        step(2);
        chk("pre_rst_ReadyM", ReadyM, 1'b0);
        RST = 1'b0;
        #1;
        model_edge();
        chk("async_ValidW", ValidW, 1'b0);
        chk("async_ReadyM", ReadyM, 1'b1);
        chk("async_ResultW", ResultW, 32'h0);
        step();
        setin(1'b0, '0, '0, '0, 1'b0, 1'b0);
        RST = 1'b1;
        step();

`ifdef WB_PERF_CNT_EN
        // 3 writing retirements and 5 stall cycles from a clean reset
        RST = 1'b0;
        #1;
        model_edge();
        step();
        RST = 1'b1;
        ReadyW = 1'b0;
        setin(1'b1, 32'h501, 32'h0, 5'd1, 1'b1, 1'b0);
        step();
        setin(1'b1, 32'h502, 32'h0, 5'd2, 1'b1, 1'b0);
        step();
        setin(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step(4);
        ReadyW = 1'b1;
        step();
        setin(1'b1, 32'h503, 32'h0, 5'd3, 1'b1, 1'b0);
        step();
        setin(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step();
        chk("perf_RetireCnt", RetireCnt, 32'd3);
        chk("perf_StallCnt", StallCnt, 32'd5);
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        step();
        chk("perf_flush_RetireCnt", RetireCnt, 32'd3);
        chk("perf_flush_StallCnt", StallCnt, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
